// File: rtl/alu_op_sequencer.sv
// Request-side sequencer for a combinational ALU: queues operations, drives one at a
// time onto the ALU inputs, waits a settle interval and returns results in order.
module alu_op_sequencer #(
    parameter int WIDTH  = 3,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_mode,
    input  logic             req_c_in,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_mode,
    output logic             alu_c_in,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_c_out,
    output logic [1:0]       rsp_mode,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       mode;
        logic             c_in;
    } op_t;

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    op_t           mem [DEPTH];
    op_t           head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] settle_cnt;
    state_t        state;
    logic          full, push, pop;

    assign full      = (count == FULL_CNT);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    // Pops come only from the FSM: leaving IDLE, or chaining straight out of RESP.
    assign pop       = (count != '0) && ((state == IDLE) || (state == RESP && rsp_ready));
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= op_t'{req_a, req_b, req_mode, req_c_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            settle_cnt <= '0;
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_mode   <= '0;
            alu_c_in   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_c_out  <= 1'b0;
            rsp_mode   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a      <= head.a;
                        alu_b      <= head.b;
                        alu_mode   <= head.mode;
                        alu_c_in   <= head.c_in;
                        settle_cnt <= '0;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == LAST_CNT) begin
                        rsp_result <= alu_result;
                        // Logic modes have no meaningful carry.
                        rsp_c_out  <= alu_mode[1] ? 1'b0 : alu_c_out;
                        rsp_mode   <= alu_mode;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (pop) begin
                            alu_a      <= head.a;
                            alu_b      <= head.b;
                            alu_mode   <= head.mode;
                            alu_c_in   <= head.c_in;
                            settle_cnt <= '0;
                            state      <= DRIVE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU on the alu_* ports;
// a second instance built with SETTLE=3 covers the longer settle interval.
module tb_alu_op_sequencer;
    localparam int W = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         req_valid, req_ready, req_c_in, alu_c_in, alu_c_out;
    logic [W-1:0] req_a, req_b, alu_a, alu_b, alu_result, rsp_result;
    logic [1:0]   req_mode, alu_mode, rsp_mode;
    logic         rsp_valid, rsp_ready, rsp_c_out, busy;

    logic         req_valid3, req_ready3, alu_c_in3, alu_c_out3;
    logic [W-1:0] alu_a3, alu_b3, alu_result3, rsp_result3;
    logic [1:0]   alu_mode3, rsp_mode3;
    logic         rsp_valid3, rsp_ready3, rsp_c_out3, busy3;

    // Behavioural ALU; logic modes drive c_out high so the sequencer's masking is visible.
    function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] m, input logic ci);
        case (m)
            2'b00:   return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            2'b01:   return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
            2'b10:   return {1'b1, a ^ b};
            default: return {1'b1, a & b};
        endcase
    endfunction

    assign {alu_c_out, alu_result}   = alu_f(alu_a, alu_b, alu_mode, alu_c_in);
    assign {alu_c_out3, alu_result3} = alu_f(alu_a3, alu_b3, alu_mode3, alu_c_in3);

    alu_op_sequencer #(.WIDTH(W), .DEPTH(4), .SETTLE(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_mode(req_mode), .req_c_in(req_c_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_c_in(alu_c_in),
        .alu_result(alu_result), .alu_c_out(alu_c_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_c_out(rsp_c_out), .rsp_mode(rsp_mode),
        .busy(busy)
    );

    alu_op_sequencer #(.WIDTH(W), .DEPTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a), .req_b(req_b), .req_mode(req_mode), .req_c_in(req_c_in),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_mode(alu_mode3), .alu_c_in(alu_c_in3),
        .alu_result(alu_result3), .alu_c_out(alu_c_out3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_result(rsp_result3), .rsp_c_out(rsp_c_out3), .rsp_mode(rsp_mode3),
        .busy(busy3)
    );

    typedef struct {
        int res;
        int co;
        int mode;
    } exp_t;

    exp_t sb[$];
    int   rsp_cyc[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: a response seen with rsp_ready high here is consumed on the next edge.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got result %0d, expected no response", rsp_result);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_result", int'(rsp_result), mon_e.res);
                chk("rsp_c_out", int'(rsp_c_out), mon_e.co);
                chk("rsp_mode", int'(rsp_mode), mon_e.mode);
                rsp_cyc.push_back(cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int r, input int co, input int m);
        exp_t e;
        e.res = r;
        e.co = co;
        e.mode = m;
        sb.push_back(e);
    endtask

    task automatic send(input int a, input int b, input int m, input int ci,
                        input int eres, input int eco, output bit acc);
        req_a = W'(a);
        req_b = W'(b);
        req_mode = 2'(m);
        req_c_in = 1'(ci);
        req_valid = 1'b1;
        @(negedge clk);
        acc = req_ready;
        if (acc) push_exp(eres, eco, m);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int lim);
        int k = 0;
        while (sb.size() != 0 && k < lim) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_remaining", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int t3a[6]  = '{1, 2, 7, 4, 2, 3};
    int t3b[6]  = '{1, 3, 7, 6, 7, 3};
    int t3m[6]  = '{0, 0, 0, 1, 2, 3};
    int t3c[6]  = '{0, 1, 1, 0, 0, 0};
    int t3r[6]  = '{2, 6, 7, 6, 5, 3};
    int t3o[6]  = '{0, 0, 1, 0, 0, 0};

    initial begin
        bit acc;
        int nacc;
        req_valid = 0; req_a = 0; req_b = 0; req_mode = 0; req_c_in = 0;
        rsp_ready = 0; req_valid3 = 0; rsp_ready3 = 1;
        reset = 1;
        step(2);
        chk("reset_req_ready", int'(req_ready), 1);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_alu_a", int'(alu_a), 0);
        chk("reset_alu_mode", int'(alu_mode), 0);
        chk("reset_rsp_result", int'(rsp_result), 0);
        reset = 0;
        step(1);

        // Single op and its latency
        rsp_ready = 1;
        send(3, 2, 0, 0, 5, 0, acc);
        step(1);
        chk("t1_rsp_valid_early", int'(rsp_valid), 0);
        chk("t1_alu_a", int'(alu_a), 3);
        chk("t1_alu_b", int'(alu_b), 2);
        chk("t1_busy", int'(busy), 1);
        step(1);
        chk("t1_rsp_valid", int'(rsp_valid), 1);
        wait_drain(20);
        step(2);

        // Ordered stream, one response every two cycles
        rsp_cyc.delete();
        send(7, 1, 0, 0, 0, 1, acc);
        send(6, 3, 1, 0, 3, 1, acc);
        send(5, 3, 2, 0, 6, 0, acc);
        send(5, 3, 3, 0, 1, 0, acc);
        wait_drain(40);
        step(1);
        chk("t2_rsp_count", rsp_cyc.size(), 4);
        if (rsp_cyc.size() == 4)
            for (int i = 1; i < 4; i++) chk("t2_spacing", rsp_cyc[i] - rsp_cyc[i-1], 2);
        step(2);

        // Backpressure: only DEPTH+1 accepted, held response stays stable
        rsp_ready = 0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            send(t3a[i], t3b[i], t3m[i], t3c[i], t3r[i], t3o[i], acc);
            if (acc) nacc++;
        end
        chk("t3_accepted", nacc, 5);
        chk("t3_req_ready_full", int'(req_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t3_hold_valid", int'(rsp_valid), 1);
            chk("t3_hold_result", int'(rsp_result), 2);
            chk("t3_req_ready_held", int'(req_ready), 0);
        end
        rsp_ready = 1;
        wait_drain(60);
        step(2);
        chk("t3_busy_after", int'(busy), 0);
        chk("t3_req_ready_after", int'(req_ready), 1);

        // Push and pop on the same edge with DEPTH-1 entries queued
        rsp_ready = 0;
        send(1, 2, 0, 0, 3, 0, acc);
        step(2);
        send(3, 4, 0, 0, 7, 0, acc);
        send(5, 5, 0, 0, 2, 1, acc);
        send(6, 1, 1, 0, 5, 1, acc);
        chk("t4_count_before", int'(dut.count), 3);
        req_a = 4; req_b = 4; req_mode = 2; req_c_in = 0;
        req_valid = 1;
        rsp_ready = 1;
        @(negedge clk);
        chk("t4_req_ready", int'(req_ready), 1);
        if (req_ready) push_exp(0, 0, 2);
        @(posedge clk);
        #1;
        req_valid = 0;
        rsp_ready = 0;
        chk("t4_count_after", int'(dut.count), 3);
        rsp_ready = 1;
        wait_drain(60);
        step(2);
        chk("t4_busy_after", int'(busy), 0);

        // Reset while driving with three entries queued
        rsp_ready = 0;
        send(1, 0, 0, 0, 1, 0, acc);
        step(2);
        send(1, 1, 0, 0, 2, 0, acc);
        send(1, 2, 0, 0, 3, 0, acc);
        send(1, 3, 0, 0, 4, 0, acc);
        send(1, 4, 0, 0, 5, 0, acc);
        rsp_ready = 1;
        step(1);
        rsp_ready = 0;
        chk("t5_in_drive_valid", int'(rsp_valid), 0);
        chk("t5_in_drive_count", int'(dut.count), 3);
        reset = 1;
        sb.delete();
        step(1);
        chk("t5_rsp_valid", int'(rsp_valid), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_req_ready", int'(req_ready), 1);
        chk("t5_alu_a", int'(alu_a), 0);
        reset = 0;
        rsp_ready = 1;
        step(1);
        send(2, 2, 1, 0, 0, 1, acc);
        wait_drain(20);
        step(2);
        chk("t5_busy_after", int'(busy), 0);

        // SETTLE=3 instance: operands held three cycles, result after edge t+4
        req_a = 2; req_b = 2; req_mode = 0; req_c_in = 0;
        req_valid3 = 1;
        step(1);
        req_valid3 = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t6_alu_a", int'(alu_a3), 2);
            chk("t6_alu_b", int'(alu_b3), 2);
            chk("t6_alu_mode", int'(alu_mode3), 0);
            chk("t6_rsp_valid_early", int'(rsp_valid3), 0);
        end
        step(1);
        chk("t6_rsp_valid", int'(rsp_valid3), 1);
        chk("t6_rsp_result", int'(rsp_result3), 4);
        chk("t6_rsp_c_out", int'(rsp_c_out3), 0);
        step(2);
        chk("t6_busy_after", int'(busy3), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
